// File: rtl/intr_edge_pending_if.sv
// Bus between the interrupt pending controller (slave) and its consumer and
// source side (master): levels, mask, claim/complete handshake, lost flags.
interface intr_edge_pending_if #(
    parameter int INTR_WIDTH = 8,
    parameter int ID_WIDTH   = 3
);
    logic [INTR_WIDTH-1:0] intr_in;
    logic [INTR_WIDTH-1:0] intr_mask;
    logic                  irq_out;
    logic                  claim_valid;
    logic [ID_WIDTH-1:0]   claim_id;
    logic                  claim_ready;
    logic                  complete_valid;
    logic [ID_WIDTH-1:0]   complete_id;
    logic [INTR_WIDTH-1:0] lost;
    logic [INTR_WIDTH-1:0] lost_clr;

    modport master (
        output intr_in, intr_mask, claim_ready, complete_valid, complete_id, lost_clr,
        input  irq_out, claim_valid, claim_id, lost
    );

    modport slave (
        input  intr_in, intr_mask, claim_ready, complete_valid, complete_id, lost_clr,
        output irq_out, claim_valid, claim_id, lost
    );
endinterface

// File: rtl/intr_edge_pending.sv
// Rising-edge interrupt pending controller: per-source edge latch cells plus a
// lowest-index-first claim FSM with a one-cycle gap after every accept.
module intr_src_cell (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    input  logic accept_i,
    input  logic complete_i,
    input  logic lost_clr_i,
    output logic pending_o,
    output logic in_svc_o,
    output logic lost_o
);
    logic in_q, prev_q, pending_q, in_svc_q, lost_q;
    logic pending_d, in_svc_d, lost_d, edge_det;

    assign edge_det  = in_q & ~prev_q;
    // New edges win over the clearing events on the same cycle.
    assign pending_d = edge_det | (pending_q & ~accept_i);
    assign lost_d    = (edge_det & pending_q & ~accept_i) | (lost_q & ~lost_clr_i);
    assign in_svc_d  = accept_i | (in_svc_q & ~complete_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q      <= 1'b0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
            in_svc_q  <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            in_q      <= in_i;
            prev_q    <= in_q;
            pending_q <= pending_d;
            in_svc_q  <= in_svc_d;
            lost_q    <= lost_d;
        end
    end

    assign pending_o = pending_q;
    assign in_svc_o  = in_svc_q;
    assign lost_o    = lost_q;
endmodule

module intr_edge_pending #(
    parameter int INTR_WIDTH = 8,
    parameter int ID_WIDTH   = 3
) (
    input  logic              clk,
    input  logic              rst,
    intr_edge_pending_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

    state_t                state_q;
    logic                  claim_valid_q, irq_q;
    logic [ID_WIDTH-1:0]   claim_id_q, low_id;
    logic [INTR_WIDTH-1:0] pending, in_svc, lost_bits, cand;
    logic [INTR_WIDTH-1:0] offered, accept, complete;
    logic                  accept_any, withdraw;

    assign cand       = pending & bus.intr_mask & ~in_svc;
    assign accept_any = (state_q == OFFER) && bus.claim_ready;
    assign accept     = offered & {INTR_WIDTH{accept_any}};
    assign withdraw   = ~|(offered & bus.intr_mask);

    // Out-of-range complete ids decode to no source and are dropped.
    for (genvar g = 0; g < INTR_WIDTH; g++) begin : g_src
        assign offered[g]  = (claim_id_q == ID_WIDTH'(g));
        assign complete[g] = bus.complete_valid && (bus.complete_id == ID_WIDTH'(g));
        intr_src_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .in_i       (bus.intr_in[g]),
            .accept_i   (accept[g]),
            .complete_i (complete[g]),
            .lost_clr_i (bus.lost_clr[g]),
            .pending_o  (pending[g]),
            .in_svc_o   (in_svc[g]),
            .lost_o     (lost_bits[g])
        );
    end

    always_comb begin
        low_id = '0;
        for (int i = INTR_WIDTH - 1; i >= 0; i--)
            if (cand[i]) low_id = ID_WIDTH'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            irq_q <= |cand;
            case (state_q)
                IDLE: if (|cand) begin
                    claim_id_q    <= low_id;
                    claim_valid_q <= 1'b1;
                    state_q       <= OFFER;
                end
                // Offer is held without preemption; only accept or mask-off ends it.
                OFFER: if (bus.claim_ready) begin
                    claim_valid_q <= 1'b0;
                    state_q       <= GAP;
                end else if (withdraw) begin
                    claim_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.irq_out     = irq_q;
    assign bus.claim_valid = claim_valid_q;
    assign bus.claim_id    = claim_id_q;
    assign bus.lost        = lost_bits;
endmodule

// File: tb/tb_intr_edge_pending.sv
// Directed bench for intr_edge_pending: each scenario task drives vectors and
// checks hand-computed outputs one cycle at a time.
module tb_intr_edge_pending;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    intr_edge_pending_if #(.INTR_WIDTH(8), .ID_WIDTH(3)) bus ();

    intr_edge_pending #(.INTR_WIDTH(8), .ID_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.intr_in = '0; bus.intr_mask = '0; bus.claim_ready = 1'b0;
        bus.complete_valid = 1'b0; bus.complete_id = '0; bus.lost_clr = '0;
        rst = 1'b1;
        step(); step();
        checks++; if (bus.irq_out !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", bus.irq_out); end
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.claim_valid); end
        checks++; if (bus.claim_id !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.claim_id); end
        checks++; if (bus.lost !== 8'h00) begin failures++; $display("FAIL reset_lost got=%h exp=00", bus.lost); end
        rst = 1'b0;
        step(); step();
    endtask

    task automatic test_lost();
        bus.intr_mask = 8'h00;
        bus.intr_in = 8'h08; step(); bus.intr_in = 8'h00; step(); step();
        checks++; if (bus.lost !== 8'h00) begin failures++; $display("FAIL lost_first got=%h exp=00", bus.lost); end
        bus.intr_in = 8'h08; step(); bus.intr_in = 8'h00;
        checks++; if (bus.lost !== 8'h00) begin failures++; $display("FAIL lost_early got=%h exp=00", bus.lost); end
        step();
        checks++; if (bus.lost !== 8'h08) begin failures++; $display("FAIL lost_set got=%h exp=08", bus.lost); end
        step();
        bus.intr_in = 8'h08; step(); bus.intr_in = 8'h00; bus.lost_clr = 8'h08; step(); bus.lost_clr = 8'h00;
        checks++; if (bus.lost !== 8'h08) begin failures++; $display("FAIL lost_set_wins got=%h exp=08", bus.lost); end
        step(); bus.lost_clr = 8'h08; step(); bus.lost_clr = 8'h00;
        checks++; if (bus.lost !== 8'h00) begin failures++; $display("FAIL lost_clear got=%h exp=00", bus.lost); end
        // drain pending[3] so later scenarios start clean
        bus.intr_mask = 8'h08; step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd3) begin failures++; $display("FAIL lost_drain_offer got=%0b/%0d exp=1/3", bus.claim_valid, bus.claim_id); end
        bus.claim_ready = 1'b1; step(); bus.claim_ready = 1'b0;
        bus.complete_valid = 1'b1; bus.complete_id = 3'd3; step(); bus.complete_valid = 1'b0;
        bus.intr_mask = 8'h00; step(); step();
    endtask

    task automatic test_single();
        bus.intr_mask = 8'hFF;
        bus.intr_in = 8'h20; step(); bus.intr_in = 8'h00; step();
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%0b exp=0", bus.claim_valid); end
        step();
        checks++; if (bus.claim_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", bus.claim_valid); end
        checks++; if (bus.claim_id !== 3'd5) begin failures++; $display("FAIL single_id got=%0d exp=5", bus.claim_id); end
        checks++; if (bus.irq_out !== 1'b1) begin failures++; $display("FAIL single_irq got=%0b exp=1", bus.irq_out); end
        step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd5) begin failures++; $display("FAIL single_hold got=%0b/%0d exp=1/5", bus.claim_valid, bus.claim_id); end
        bus.claim_ready = 1'b1; step(); bus.claim_ready = 1'b0;
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL single_accept_drop got=%0b exp=0", bus.claim_valid); end
        step();
        checks++; if (bus.irq_out !== 1'b0) begin failures++; $display("FAIL single_irq_clear got=%0b exp=0", bus.irq_out); end
        bus.complete_valid = 1'b1; bus.complete_id = 3'd5; step(); bus.complete_valid = 1'b0;
        step(); step();
        checks++; if (bus.irq_out !== 1'b0 || bus.claim_valid !== 1'b0) begin failures++; $display("FAIL single_after_complete got=%0b/%0b exp=0/0", bus.irq_out, bus.claim_valid); end
    endtask

    task automatic test_priority();
        bus.intr_mask = 8'hFF;
        bus.intr_in = 8'h40; step(); bus.intr_in = 8'h44; step(); step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd6) begin failures++; $display("FAIL prio_first got=%0b/%0d exp=1/6", bus.claim_valid, bus.claim_id); end
        step(); step();
        checks++; if (bus.claim_id !== 3'd6) begin failures++; $display("FAIL prio_stable got=%0d exp=6", bus.claim_id); end
        bus.claim_ready = 1'b1; step(); bus.claim_ready = 1'b0;
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL prio_accept got=%0b exp=0", bus.claim_valid); end
        step();
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL prio_gap got=%0b exp=0", bus.claim_valid); end
        checks++; if (bus.irq_out !== 1'b1) begin failures++; $display("FAIL prio_irq_held got=%0b exp=1", bus.irq_out); end
        step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd2) begin failures++; $display("FAIL prio_second got=%0b/%0d exp=1/2", bus.claim_valid, bus.claim_id); end
        bus.claim_ready = 1'b1; step(); bus.claim_ready = 1'b0;
        bus.complete_valid = 1'b1; bus.complete_id = 3'd6; step();
        bus.complete_id = 3'd2; step(); bus.complete_valid = 1'b0;
        bus.intr_in = 8'h00; step(); step();
    endtask

    task automatic test_rearm();
        bus.intr_mask = 8'hFF;
        bus.intr_in = 8'h10; step(); bus.intr_in = 8'h00; step(); step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd4) begin failures++; $display("FAIL rearm_offer got=%0b/%0d exp=1/4", bus.claim_valid, bus.claim_id); end
        bus.claim_ready = 1'b1; step(); bus.claim_ready = 1'b0; step(); step();
        bus.intr_in = 8'h10; step(); bus.intr_in = 8'h00; step(); step(); step();
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL rearm_no_offer got=%0b exp=0", bus.claim_valid); end
        checks++; if (bus.irq_out !== 1'b0) begin failures++; $display("FAIL rearm_no_irq got=%0b exp=0", bus.irq_out); end
        bus.complete_valid = 1'b1; bus.complete_id = 3'd4; step(); bus.complete_valid = 1'b0;
        step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd4) begin failures++; $display("FAIL rearm_reoffer got=%0b/%0d exp=1/4", bus.claim_valid, bus.claim_id); end
        checks++; if (bus.irq_out !== 1'b1) begin failures++; $display("FAIL rearm_irq got=%0b exp=1", bus.irq_out); end
        bus.claim_ready = 1'b1; step(); bus.claim_ready = 1'b0;
        bus.complete_valid = 1'b1; bus.complete_id = 3'd4; step(); bus.complete_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_mask();
        bus.intr_mask = 8'h00;
        bus.intr_in = 8'h02; step(); bus.intr_in = 8'h00; step(); step(); step();
        checks++; if (bus.irq_out !== 1'b0 || bus.claim_valid !== 1'b0) begin failures++; $display("FAIL mask_blocked got=%0b/%0b exp=0/0", bus.irq_out, bus.claim_valid); end
        bus.intr_mask = 8'h02; step();
        checks++; if (bus.irq_out !== 1'b1) begin failures++; $display("FAIL mask_irq got=%0b exp=1", bus.irq_out); end
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd1) begin failures++; $display("FAIL mask_offer got=%0b/%0d exp=1/1", bus.claim_valid, bus.claim_id); end
        bus.intr_mask = 8'h00; step();
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL mask_withdraw got=%0b exp=0", bus.claim_valid); end
        checks++; if (bus.irq_out !== 1'b0) begin failures++; $display("FAIL mask_irq_off got=%0b exp=0", bus.irq_out); end
    endtask

    task automatic test_reset_mid();
        // source 1 is still pending from the mask scenario
        bus.intr_mask = 8'hFF; bus.intr_in = 8'h80; step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd1) begin failures++; $display("FAIL rstmid_offer got=%0b/%0d exp=1/1", bus.claim_valid, bus.claim_id); end
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", bus.claim_valid); end
        checks++; if (bus.claim_id !== 3'd0) begin failures++; $display("FAIL rstmid_id got=%0d exp=0", bus.claim_id); end
        checks++; if (bus.irq_out !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%0b exp=0", bus.irq_out); end
        step(); step();
        rst = 1'b0;
        step(); step();
        checks++; if (bus.claim_valid !== 1'b0) begin failures++; $display("FAIL rstmid_early got=%0b exp=0", bus.claim_valid); end
        step();
        checks++; if (bus.claim_valid !== 1'b1 || bus.claim_id !== 3'd7) begin failures++; $display("FAIL rstmid_held_src got=%0b/%0d exp=1/7", bus.claim_valid, bus.claim_id); end
        checks++; if (bus.irq_out !== 1'b1) begin failures++; $display("FAIL rstmid_held_irq got=%0b exp=1", bus.irq_out); end
    endtask

    initial begin
        test_reset();
        test_lost();
        test_single();
        test_priority();
        test_rearm();
        test_mask();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
